// File: rtl/vga_box_animator.sv
// Pixel stage behind the VGA timing generator: draws a diagonally bouncing box that changes colour on each bounce.
// Optional build macro VGA_BOX_BORDER_EN adds a white one-pixel frame around the active area.
module vga_box_animator #(
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int H_ACTIVE  = 640,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int V_ACTIVE  = 480,
   parameter int BOX_W     = 64,
   parameter int BOX_H     = 48,
   parameter int STEP      = 4,
   parameter int FRAME_DIV = 1
) (
   input  logic       VGA_CLK,
   input  logic       RESET,
   input  logic [9:0] HS_count,
   input  logic [9:0] VS_count,
   input  logic       RUN,
   output logic [3:0] VGA_R,
   output logic [3:0] VGA_G,
   output logic [3:0] VGA_B
);

   typedef enum logic [0:0] {WAIT_FRAME = 1'b0, UPDATE = 1'b1} state_t;

   localparam logic [10:0] H_START  = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [10:0] V_START  = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] V_END    = 11'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BOX_W);
   localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BOX_H);
   localparam logic [10:0] BOX_W_L  = 11'(BOX_W);
   localparam logic [10:0] BOX_H_L  = 11'(BOX_H);
   localparam logic [10:0] STEP_L   = 11'(STEP);
   localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);
`ifdef VGA_BOX_BORDER_EN
   localparam logic [10:0] PX_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] PY_LAST  = 11'(V_ACTIVE - 1);
`endif

   // Returns {hit, moving_negative, new_pos}; pos arithmetic is 11 bits so it never wraps.
   function automatic logic [12:0] move_axis(input logic [10:0] pos, input logic neg,
                                             input logic [10:0] lim);
      logic [12:0] res;
      if (!neg) begin
         if (pos + STEP_L >= lim) res = {1'b1, 1'b1, lim};
         else                     res = {1'b0, 1'b0, pos + STEP_L};
      end else begin
         if (pos <= STEP_L) res = {1'b1, 1'b0, 11'd0};
         else               res = {1'b0, 1'b1, pos - STEP_L};
      end
      return res;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  frame_cnt_q, frame_cnt_d;
   logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [2:0]  color_q, color_d;
   logic [11:0] rgb_q, rgb_d;
   logic [10:0] hs_s, vs_s, px_s, py_s;
   logic [12:0] mv_x_s, mv_y_s;
   logic        h_act_s, v_act_s, in_box_s, frame_tick_s;

   assign hs_s         = {1'b0, HS_count};
   assign vs_s         = {1'b0, VS_count};
   assign px_s         = hs_s - H_START;
   assign py_s         = vs_s - V_START;
   assign h_act_s      = (hs_s >= H_START) && (hs_s < H_END);
   assign v_act_s      = (vs_s >= V_START) && (vs_s < V_END);
   assign in_box_s     = (px_s >= box_x_q) && (px_s < box_x_q + BOX_W_L) &&
                         (py_s >= box_y_q) && (py_s < box_y_q + BOX_H_L);
   assign frame_tick_s = (HS_count == 10'd0) && (VS_count == 10'd0);
   assign mv_x_s       = move_axis(box_x_q, dir_x_q, X_MAX);
   assign mv_y_s       = move_axis(box_y_q, dir_y_q, Y_MAX);

   // Frame divider FSM; position and colour change only in the single UPDATE cycle.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      box_x_d     = box_x_q;
      box_y_d     = box_y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      color_d     = color_q;
      case (state_q)
         WAIT_FRAME: begin
            if (frame_tick_s && RUN) begin
               if (frame_cnt_q == DIV_LAST) begin
                  frame_cnt_d = 4'd0;
                  state_d     = UPDATE;
               end else begin
                  frame_cnt_d = frame_cnt_q + 4'd1;
               end
            end else begin
               frame_cnt_d = frame_cnt_q;
            end
         end
         UPDATE: begin
            state_d = WAIT_FRAME;
            {dir_x_d, box_x_d} = mv_x_s[11:0];
            {dir_y_d, box_y_d} = mv_y_s[11:0];
            if (mv_x_s[12] || mv_y_s[12]) begin
               color_d = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
            end else begin
               color_d = color_q;
            end
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   // Pixel colour selection, registered below for one cycle of latency.
   always_comb begin
      rgb_d = 12'h000;
      if (h_act_s && v_act_s) begin
`ifdef VGA_BOX_BORDER_EN
         if ((px_s == 11'd0) || (px_s == PX_LAST) || (py_s == 11'd0) || (py_s == PY_LAST))
            rgb_d = 12'hFFF;
         else
`endif
         if (in_box_s) rgb_d = {{4{color_q[2]}}, {4{color_q[1]}}, {4{color_q[0]}}};
         else          rgb_d = 12'h002;
      end else begin
         rgb_d = 12'h000;
      end
   end

   // State, animation and output registers.
   always_ff @(posedge VGA_CLK) begin
      if (RESET) begin
         state_q     <= WAIT_FRAME;
         frame_cnt_q <= 4'd0;
         box_x_q     <= 11'd0;
         box_y_q     <= 11'd0;
         dir_x_q     <= 1'b0;
         dir_y_q     <= 1'b0;
         color_q     <= 3'd1;
         rgb_q       <= 12'h000;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         color_q     <= color_d;
         rgb_q       <= rgb_d;
      end
   end

   assign VGA_R = rgb_q[11:8];
   assign VGA_G = rgb_q[7:4];
   assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_box_animator.sv
// Bench for vga_box_animator: two instances (FRAME_DIV 1 and 3) driven with synthetic counter values
// and checked against a behavioural model through a queue-based scoreboard.
module tb_vga_box_animator;
   logic       clk = 1'b0;
   logic       rst, run;
   logic [9:0] hs, vs;
   logic [3:0] r0, g0, b0, r3, g3, b3;

   always #5 clk = ~clk;

   vga_box_animator dut (
      .VGA_CLK(clk), .RESET(rst), .HS_count(hs), .VS_count(vs), .RUN(run),
      .VGA_R(r0), .VGA_G(g0), .VGA_B(b0));

   vga_box_animator #(.FRAME_DIV(3)) dut3 (
      .VGA_CLK(clk), .RESET(rst), .HS_count(hs), .VS_count(vs), .RUN(run),
      .VGA_R(r3), .VGA_G(g3), .VGA_B(b3));

`ifdef VGA_BOX_BORDER_EN
   localparam logic [11:0] EXP_ORIGIN = 12'hFFF;
   localparam logic [11:0] EXP_TOPROW = 12'hFFF;
`else
   localparam logic [11:0] EXP_ORIGIN = 12'h00F;
   localparam logic [11:0] EXP_TOPROW = 12'h002;
`endif

   int checks = 0;
   int errors = 0;
   logic [11:0] q0[$];
   logic [11:0] q3[$];
   logic [11:0] e0, e3;

   int       mx[2], my[2], mcnt[2];
   bit       mdx[2], mdy[2], pend[2];
   logic [2:0] mcol[2];
   int       divs[2] = '{1, 3};
   int       dxs[6]  = '{-1, 0, 63, 64, 0, 0};
   int       dys[6]  = '{0, 0, 47, 0, -1, 48};

   function automatic logic [11:0] exp_pix(int k, int h, int v);
      int px, py;
      if (h < 144 || h >= 784 || v < 35 || v >= 515) return 12'h000;
      px = h - 144;
      py = v - 35;
`ifdef VGA_BOX_BORDER_EN
      if (px == 0 || px == 639 || py == 0 || py == 479) return 12'hFFF;
`endif
      if (px >= mx[k] && px < mx[k] + 64 && py >= my[k] && py < my[k] + 48)
         return {{4{mcol[k][2]}}, {4{mcol[k][1]}}, {4{mcol[k][0]}}};
      return 12'h002;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0;
         mcol[k] = 3'd1; mcnt[k] = 0; pend[k] = 0;
      end
   endtask

   task automatic model_move(int k);
      bit hit = 0;
      if (!mdx[k]) begin
         if (mx[k] + 4 >= 576) begin mx[k] = 576; mdx[k] = 1; hit = 1; end
         else mx[k] += 4;
      end else begin
         if (mx[k] <= 4) begin mx[k] = 0; mdx[k] = 0; hit = 1; end
         else mx[k] -= 4;
      end
      if (!mdy[k]) begin
         if (my[k] + 4 >= 432) begin my[k] = 432; mdy[k] = 1; hit = 1; end
         else my[k] += 4;
      end else begin
         if (my[k] <= 4) begin my[k] = 0; mdy[k] = 0; hit = 1; end
         else my[k] -= 4;
      end
      if (hit) mcol[k] = (mcol[k] == 3'd7) ? 3'd1 : mcol[k] + 3'd1;
   endtask

   // One clock: expected pixel is taken from the pre-edge model state.
   task automatic drive(input int h, input int v, input logic rn, input logic r, input bit push);
      hs = 10'(h); vs = 10'(v); run = rn; rst = r;
      if (push) begin
         q0.push_back(r ? 12'h000 : exp_pix(0, h, v));
         q3.push_back(r ? 12'h000 : exp_pix(1, h, v));
      end
      @(posedge clk);
      if (r) model_reset();
      else begin
         for (int k = 0; k < 2; k++) begin
            if (pend[k]) begin model_move(k); pend[k] = 0; end
            else if (h == 0 && v == 0 && rn) begin
               if (mcnt[k] == divs[k] - 1) begin mcnt[k] = 0; pend[k] = 1; end
               else mcnt[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic frames(input int n, input logic rn);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, rn, 1'b0, 1'b0);
         drive(1, 0, rn, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      drive(500, 300, 1'b0, 1'b1, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL reset_out0 got %h want %h", {r0, g0, b0}, e0); end
      if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL reset_out3 got %h want %h", {r3, g3, b3}, e3); end
      for (int k = 0; k < 2; k++) for (int i = 0; i < 6; i++) begin
         drive(144 + mx[k] + dxs[i], 35 + my[k] + dys[i], 1'b0, 1'b0, 1'b1);
         e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
         if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL reset_probe0 i=%0d got %h want %h", i, {r0, g0, b0}, e0); end
         if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL reset_probe3 i=%0d got %h want %h", i, {r3, g3, b3}, e3); end
      end
   endtask

   task automatic test_sweep();
      int hh[4] = '{144, 208, 100, 144};
      int vv[4] = '{35, 35, 35, 235};
      logic [11:0] lit[4];
      lit = '{EXP_ORIGIN, EXP_TOPROW, 12'h000, exp_pix(0, 144, 235)};
      frames(2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(hh[i], vv[i], 1'b0, 1'b0, 1'b1);
         e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 3;
         if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL sweep0 h=%0d got %h want %h", hh[i], {r0, g0, b0}, e0); end
         if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL sweep3 h=%0d got %h want %h", hh[i], {r3, g3, b3}, e3); end
         if ({r0, g0, b0} !== lit[i]) begin errors++; $display("FAIL sweep_lit h=%0d got %h want %h", hh[i], {r0, g0, b0}, lit[i]); end
      end
   endtask

   task automatic test_move();
      frames(3, 1'b1);
      drive(156, 47, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 3;
      if ({r0, g0, b0} !== 12'h00F) begin errors++; $display("FAIL move_first0 got %h want 00f", {r0, g0, b0}); end
      if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL move_sb0 got %h want %h", {r0, g0, b0}, e0); end
      if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL move_sb3 got %h want %h", {r3, g3, b3}, e3); end
      drive(155, 47, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r0, g0, b0} !== 12'h002) begin errors++; $display("FAIL move_left0 got %h want 002", {r0, g0, b0}); end
      if ({r3, g3, b3} !== 12'h00F) begin errors++; $display("FAIL move_left3 got %h want 00f", {r3, g3, b3}); end
   endtask

   task automatic test_div_pause();
      frames(1, 1'b1);
      frames(2, 1'b0);
      frames(1, 1'b1);
      drive(151, 39, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r3, g3, b3} !== 12'h00F) begin errors++; $display("FAIL pause_hold3 got %h want 00f", {r3, g3, b3}); end
      if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL pause_sb0 got %h want %h", {r0, g0, b0}, e0); end
      frames(1, 1'b1);
      drive(151, 43, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r3, g3, b3} !== 12'h002) begin errors++; $display("FAIL pause_step3 got %h want 002", {r3, g3, b3}); end
      if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL pause_step0 got %h want %h", {r0, g0, b0}, e0); end
      drive(152, 43, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 1;
      if ({r3, g3, b3} !== 12'h00F) begin errors++; $display("FAIL pause_edge3 got %h want 00f", {r3, g3, b3}); end
   endtask

   task automatic test_update_run_drop();
      drive(0, 0, 1'b1, 1'b0, 1'b0);
      drive(1, 0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) for (int i = 0; i < 6; i++) begin
         drive(144 + mx[k] + dxs[i], 35 + my[k] + dys[i], 1'b0, 1'b0, 1'b1);
         e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
         if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL rundrop0 i=%0d got %h want %h", i, {r0, g0, b0}, e0); end
         if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL rundrop3 i=%0d got %h want %h", i, {r3, g3, b3}, e3); end
      end
   endtask

   task automatic test_reset_mid();
      frames(2, 1'b1);
      drive(0, 0, 1'b1, 1'b0, 1'b0);
      drive(300, 100, 1'b1, 1'b1, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r0, g0, b0} !== 12'h000) begin errors++; $display("FAIL rst_update0 got %h want 000", {r0, g0, b0}); end
      if ({r3, g3, b3} !== 12'h000) begin errors++; $display("FAIL rst_update3 got %h want 000", {r3, g3, b3}); end
      drive(150, 40, 1'b0, 1'b0, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
      if ({r0, g0, b0} !== 12'h00F) begin errors++; $display("FAIL rst_origin0 got %h want 00f", {r0, g0, b0}); end
      if ({r3, g3, b3} !== 12'h00F) begin errors++; $display("FAIL rst_origin3 got %h want 00f", {r3, g3, b3}); end
      drive(150, 40, 1'b0, 1'b1, 1'b1);
      e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 1;
      if ({r0, g0, b0} !== 12'h000) begin errors++; $display("FAIL rst_pixel0 got %h want 000", {r0, g0, b0}); end
   endtask

   task automatic test_bounce();
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      for (int f = 1; f <= 540; f++) begin
         frames(1, 1'b1);
         for (int i = 0; i < 6; i++) begin
            drive(144 + mx[0] + dxs[i], 35 + my[0] + dys[i], 1'b0, 1'b0, 1'b1);
            e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 2;
            if ({r0, g0, b0} !== e0) begin errors++; $display("FAIL bounce0 f=%0d i=%0d got %h want %h", f, i, {r0, g0, b0}, e0); end
            if ({r3, g3, b3} !== e3) begin errors++; $display("FAIL bounce3 f=%0d i=%0d got %h want %h", f, i, {r3, g3, b3}, e3); end
         end
         if (f == 432) begin
            drive(720, 35, 1'b0, 1'b0, 1'b1);
            e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 1;
            if ({r0, g0, b0} !== 12'hFFF) begin errors++; $display("FAIL corner_col7 got %h want fff", {r0, g0, b0}); end
         end
         if (f == 540) begin
            drive(289, 468, 1'b0, 1'b0, 1'b1);
            e0 = q0.pop_front(); e3 = q3.pop_front(); checks += 1;
            if ({r0, g0, b0} !== 12'h00F) begin errors++; $display("FAIL wrap_col1 got %h want 00f", {r0, g0, b0}); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; hs = 10'd0; vs = 10'd0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_sweep();
      test_move();
      test_div_pause();
      test_update_run_drop();
      test_reset_mid();
      test_bounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_box_animator.md
Name: vga_box_animator

Overview:
- Pixel stage that sits directly downstream of the VGA HS/VS timing generator.
- Consumes the generator's raw horizontal and vertical counters and produces registered 4-bit R/G/B.
- Draws a solid rectangle on a background. The rectangle moves diagonally, bounces off the active-area edges, and changes colour on every bounce.
- Position updates once per frame, during vertical sync, so the picture never tears.

Parameters:
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, active lines
- BOX_W, 64, rectangle width (pixels)
- BOX_H, 48, rectangle height (lines)
- STEP, 4, pixels moved per axis per update
- FRAME_DIV, 1, frames per position update (1..15)

Ports:
- VGA_CLK  in  1  pixel clock; same clock as the timing generator
- RESET  in  1  synchronous, active-high reset
- HS_count  in  10  horizontal counter from the timing generator; 0 = start of sync
- VS_count  in  10  vertical counter; advances when HS_count==0
- RUN  in  1  1 = animate; 0 = freeze position, keep drawing
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue

Behaviour:
- Interface: one clock, VGA_CLK. Reset RESET is synchronous and active-high.
- Reset values:
  - VGA_R/G/B = 0
  - box_x = 0, box_y = 0
  - dir_x = +, dir_y = +
  - color_idx = 3'd1
  - frame_cnt = 0
  - FSM = WAIT_FRAME
- RESET asserted mid-frame takes effect on the next edge and overrides all other activity.
- Active region:
  - Horizontal: HS_count in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE), i.e. [144, 784).
  - Vertical: VS_count in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE), i.e. [35, 515).
  - px = HS_count - 144; py = VS_count - 35.
- Pixel path: one cycle of latency. Counters sampled at edge N appear on R/G/B after edge N.
  - Outside the active region: R = G = B = 0.
  - Inside the box (px in [box_x, box_x+BOX_W), py in [box_y, box_y+BOX_H)): each channel is 4'hF if its colour_idx bit is set, else 0. Bit mapping: R = bit2, G = bit1, B = bit0.
  - Otherwise (background): R = 0, G = 0, B = 4'd2.
- frame_tick: a one-cycle internal pulse when HS_count==0 && VS_count==0.
- FSM, 2 states:
  - WAIT_FRAME: on frame_tick with RUN==1, increment frame_cnt. If frame_cnt == FRAME_DIV-1, clear frame_cnt and go to UPDATE.
  - With RUN==0, frame_cnt holds.
  - UPDATE: lasts exactly one cycle, applies the move and bounce rules below, then returns to WAIT_FRAME.
- Move rule, X axis (Y is identical, with V_ACTIVE and BOX_H):
  - xmax = H_ACTIVE - BOX_W.
  - dir +: if box_x + STEP >= xmax, set box_x = xmax and flip dir_x to −, flagging a hit. Else box_x += STEP.
  - dir −: if box_x <= STEP, set box_x = 0 and flip dir_x to +, flagging a hit. Else box_x -= STEP.
- Colour rule:
  - If either axis hits in an UPDATE, color_idx increments once. A corner hit on both axes still increments only once.
  - Sequence wraps 7 → 1; 0 (black box) is never produced.
- Position arithmetic: 11-bit internally so there is no underflow or overflow. box_x and box_y are always within [0, xmax] and [0, ymax].
- RUN deasserted during the UPDATE cycle does not cancel that update.

Optional Feature:
- Macro: VGA_BOX_BORDER_EN.
- Defined: active-area pixels with px==0, px==H_ACTIVE-1, py==0 or py==V_ACTIVE-1 output R = G = B = 4'hF. The border overrides both box and background.
- Latency is unchanged.
- Not defined: no border logic is present; output follows the base rules.

Test Plan:
- Apply reset, then sweep one full frame with RUN=0 and default parameters:
  - At HS_count=144, VS_count=35, the next cycle gives R/G/B = 0/0/F (colour 1).
  - At HS_count=208 the next cycle gives 0/0/2.
  - At HS_count=100 the output is 0/0/0.
- RUN=1, FRAME_DIV=1: after 3 frame_ticks, box_x = box_y = 12. The first box pixel appears at HS_count = 156 on line VS_count = 47.
- Right-wall hit, box_x preset 572 with dir +: after one update box_x = 576, dir_x = −, and color_idx goes 1 → 2. The next update gives box_x = 572.
- Corner hit, box_x = 574 and box_y = 430 with both dirs +: one update gives box_x = 576, box_y = 432, both dirs flip, and color_idx increments by exactly 1. Then from color_idx = 7, a hit gives color_idx = 1.
- FRAME_DIV=3, RUN toggled 0 for 2 frames mid-count: position changes only on every 3rd counted frame_tick, and paused frames are not counted.
- RESET asserted during UPDATE and during an active pixel: on the next cycle all outputs are 0 and position and colour are back at reset values. With VGA_BOX_BORDER_EN defined, pixel (px=0, py=200) gives F/F/F.
